// File: rtl/pongers_mem_pkg.sv
// Shared definitions for the on-chip RAM copy/fill master: op codes, FSM states, default widths.
package pongers_mem_pkg;

    localparam logic OP_COPY = 1'b0;
    localparam logic OP_FILL = 1'b1;

    localparam int unsigned MEM_ADDR_W = 15;
    localparam int unsigned MEM_DATA_W = 32;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StRdWait,
        StWr,
        StFin
    } state_e;

endpackage

// File: rtl/avalon_mem_copy_master.sv
// Avalon-MM master running word-granular COPY/FILL jobs against a fixed-latency RAM slave.
// Bus outputs are registered from the next-state values so each access lines up with its state.
module avalon_mem_copy_master
    import pongers_mem_pkg::*;
#(
    parameter int unsigned ADDR_W       = MEM_ADDR_W,
    parameter int unsigned DATA_W       = MEM_DATA_W,
    parameter int unsigned LEN_W        = ADDR_W + 1,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                op_i,
    input  logic [ADDR_W-1:0]   src_addr_i,
    input  logic [ADDR_W-1:0]   dst_addr_i,
    input  logic [LEN_W-1:0]    len_i,
    input  logic [DATA_W-1:0]   fill_data_i,
    input  logic                abort_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                aborted_o,
    output logic [LEN_W-1:0]    words_done_o,
    output logic [ADDR_W-1:0]   m_address_o,
    output logic                m_chipselect_o,
    output logic                m_write_o,
    output logic [DATA_W-1:0]   m_writedata_o,
    output logic [DATA_W/8-1:0] m_byteenable_o,
    output logic                m_clken_o,
    input  logic [DATA_W-1:0]   m_readdata_i
);

    localparam int unsigned LatW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [LatW-1:0] LatLast = LatW'(READ_LATENCY - 1);

    state_e              state_q, state_d;
    logic                op_q, op_d;
    logic [ADDR_W-1:0]   src_q, src_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [DATA_W-1:0]   fill_q, fill_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [LEN_W-1:0]    words_q, words_d;
    logic [LatW-1:0]     lat_q, lat_d;
    logic                aborted_q, aborted_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                cs_q, cs_d;
    logic                wr_q, wr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [LEN_W-1:0]    words_inc;

    assign words_inc = words_q + LEN_W'(1);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        fill_d    = fill_q;
        data_d    = data_q;
        words_d   = words_q;
        lat_d     = lat_q;
        aborted_d = aborted_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    op_d      = op_i;
                    src_d     = src_addr_i;
                    dst_d     = dst_addr_i;
                    len_d     = len_i;
                    fill_d    = fill_data_i;
                    words_d   = '0;
                    aborted_d = 1'b0;
                    if (len_i == '0) begin
                        state_d = StFin;
                    end else if (op_i == OP_FILL) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd: begin
                lat_d = '0;
                if (abort_i) begin
                    state_d   = StFin;
                    aborted_d = 1'b1;
                end else begin
                    state_d = StRdWait;
                end
            end
            StRdWait: begin
                if (abort_i) begin
                    state_d   = StFin;
                    aborted_d = 1'b1;
                end else if (lat_q == LatLast) begin
                    data_d  = m_readdata_i;
                    state_d = StWr;
                end else begin
                    lat_d = lat_q + LatW'(1);
                end
            end
            StWr: begin
                // The write for this cycle is already on the bus; abort only stops the next one.
                src_d   = src_q + ADDR_W'(1);
                dst_d   = dst_q + ADDR_W'(1);
                words_d = words_inc;
                if (abort_i) begin
                    state_d   = StFin;
                    aborted_d = 1'b1;
                end else if (words_inc == len_q) begin
                    state_d = StFin;
                end else if (op_q == OP_FILL) begin
                    state_d = StWr;
                end else begin
                    state_d = StRd;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        cs_d    = 1'b0;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = (state_q == StFin);
        busy_d  = (state_d != StIdle);

        if (state_d == StRd) begin
            cs_d   = 1'b1;
            addr_d = src_d;
        end else if (state_d == StWr) begin
            cs_d    = 1'b1;
            wr_d    = 1'b1;
            addr_d  = dst_d;
            wdata_d = (op_d == OP_FILL) ? fill_d : data_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            op_q      <= OP_COPY;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            fill_q    <= '0;
            data_q    <= '0;
            words_q   <= '0;
            lat_q     <= '0;
            aborted_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            addr_q    <= '0;
            cs_q      <= 1'b0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            fill_q    <= fill_d;
            data_q    <= data_d;
            words_q   <= words_d;
            lat_q     <= lat_d;
            aborted_q <= aborted_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            addr_q    <= addr_d;
            cs_q      <= cs_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign aborted_o      = aborted_q;
    assign words_done_o   = words_q;
    assign m_address_o    = addr_q;
    assign m_chipselect_o = cs_q;
    assign m_write_o      = wr_q;
    assign m_writedata_o  = wdata_q;
    assign m_byteenable_o = '1;
    assign m_clken_o      = 1'b1;

endmodule

// File: tb/tb_avalon_mem_copy_master.sv
// Bench for avalon_mem_copy_master: behavioural RAM slave plus read/write scoreboards.
module tb_avalon_mem_copy_master;

    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              op = 1'b0;
    logic [ADDR_W-1:0] src = '0;
    logic [ADDR_W-1:0] dst = '0;
    logic [LEN_W-1:0]  len = '0;
    logic [DATA_W-1:0] fill = '0;
    logic              abort = 1'b0;
    logic              busy, done, aborted;
    logic [LEN_W-1:0]  words_done;
    logic [ADDR_W-1:0] m_address;
    logic              m_cs, m_write, m_clken;
    logic [DATA_W-1:0] m_wdata;
    logic [3:0]        m_be;
    logic [DATA_W-1:0] m_rdata = '0;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int n_checks = 0;
    int n_fail   = 0;
    int cs_count = 0;
    logic [63:0] exp_wr_q [$];
    logic [ADDR_W-1:0] exp_rd_q [$];

    always #5 clk = ~clk;

    avalon_mem_copy_master dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .op_i          (op),
        .src_addr_i    (src),
        .dst_addr_i    (dst),
        .len_i         (len),
        .fill_data_i   (fill),
        .abort_i       (abort),
        .busy_o        (busy),
        .done_o        (done),
        .aborted_o     (aborted),
        .words_done_o  (words_done),
        .m_address_o   (m_address),
        .m_chipselect_o(m_cs),
        .m_write_o     (m_write),
        .m_writedata_o (m_wdata),
        .m_byteenable_o(m_be),
        .m_clken_o     (m_clken),
        .m_readdata_i  (m_rdata)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // RAM slave with one cycle of read latency.
    always @(posedge clk) begin
        if (m_cs && !m_write) m_rdata <= mem[m_address];
        if (m_cs && m_write) mem[m_address] <= m_wdata;
    end

    // Bus monitor: every access is popped against the scoreboards.
    always @(negedge clk) begin
        if (rst_n && m_cs) begin
            cs_count++;
            check_eq("byteenable", {60'd0, m_be}, 64'hF);
            if (m_write) begin
                if (exp_wr_q.size() == 0) begin
                    check_eq("unexpected_write", {17'd0, m_address, m_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    check_eq("write_addr_data", {17'd0, m_address, m_wdata}, exp_wr_q.pop_front());
                end
            end else begin
                if (exp_rd_q.size() == 0) begin
                    check_eq("unexpected_read", {49'd0, m_address}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    check_eq("read_addr", {49'd0, m_address}, {49'd0, exp_rd_q.pop_front()});
                end
            end
        end
    end

    function automatic logic [63:0] wr_item(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        return {17'd0, a, d};
    endfunction

    // Drives a job, optionally a stray start and an abort at given cycle numbers after the start
    // edge (0 = none). Returns the cycle in which done was seen.
    task automatic run_job(input logic o, input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                           input logic [LEN_W-1:0] l, input logic [DATA_W-1:0] f,
                           input int abort_cyc, input int stray_cyc, output int cycles);
        int n;
        @(negedge clk);
        op = o; src = s; dst = d; len = l; fill = f; start = 1'b1;
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            n++;
            start = (n == stray_cyc);
            if (n == stray_cyc) begin
                op = 1'b1; dst = 15'h0500; len = 16'd1;
            end
            abort = (n == abort_cyc);
            if (n == 1) check_eq("busy_in_job", {63'd0, busy}, 64'd1);
            if (done) break;
        end
        start = 1'b0;
        abort = 1'b0;
        if (n >= 300) check_eq("done_timeout", 64'(n), 64'd0);
        cycles = n;
        check_eq("busy_at_done", {63'd0, busy}, 64'd0);
        @(negedge clk);
        check_eq("done_one_cycle", {63'd0, done}, 64'd0);
        check_eq("wr_sb_empty", 64'(exp_wr_q.size()), 64'd0);
        check_eq("rd_sb_empty", 64'(exp_rd_q.size()), 64'd0);
    endtask

    initial begin
        int cyc;
        int cs_before;
        #12;
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_done", {63'd0, done}, 64'd0);
        check_eq("rst_aborted", {63'd0, aborted}, 64'd0);
        check_eq("rst_words", {48'd0, words_done}, 64'd0);
        check_eq("rst_cs_wr", {62'd0, m_cs, m_write}, 64'd0);
        check_eq("rst_addr_wdata", {17'd0, m_address, m_wdata}, 64'd0);
        check_eq("rst_be_clken", {59'd0, m_be, m_clken}, 64'h1F);
        @(negedge clk);
        rst_n = 1'b1;

        // FILL, four back-to-back writes.
        for (int i = 0; i < 4; i++) exp_wr_q.push_back(wr_item(15'h0100 + 15'(i), 32'hDEADBEEF));
        run_job(1'b1, 15'h0, 15'h0100, 16'd4, 32'hDEADBEEF, 0, 0, cyc);
        check_eq("fill_cycles", 64'(cyc), 64'd6);
        check_eq("fill_words", {48'd0, words_done}, 64'd4);
        check_eq("fill_aborted", {63'd0, aborted}, 64'd0);

        // COPY of three words.
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33;
        for (int i = 0; i < 3; i++) begin
            exp_rd_q.push_back(15'(i));
            exp_wr_q.push_back(wr_item(15'h0200 + 15'(i), 32'h11 * 32'(i + 1)));
        end
        run_job(1'b0, 15'h0, 15'h0200, 16'd3, 32'h0, 0, 0, cyc);
        check_eq("copy_cycles", 64'(cyc), 64'd11);
        check_eq("copy_words", {48'd0, words_done}, 64'd3);
        check_eq("copy_ram", {mem[15'h200][7:0], mem[15'h201][7:0], mem[15'h202][7:0]}, 64'h112233);

        // Destination wraps past the top of the address space.
        exp_wr_q.push_back(wr_item(15'h7FFE, 32'hA5A5_0001));
        exp_wr_q.push_back(wr_item(15'h7FFF, 32'hA5A5_0001));
        exp_wr_q.push_back(wr_item(15'h0000, 32'hA5A5_0001));
        run_job(1'b1, 15'h0, 15'h7FFE, 16'd3, 32'hA5A5_0001, 0, 0, cyc);
        check_eq("wrap_cycles", 64'(cyc), 64'd5);
        check_eq("wrap_words", {48'd0, words_done}, 64'd3);

        // Zero-length job: no bus activity.
        cs_before = cs_count;
        run_job(1'b0, 15'h0010, 15'h0300, 16'd0, 32'h0, 0, 0, cyc);
        check_eq("len0_cycles", 64'(cyc), 64'd2);
        check_eq("len0_no_cs", 64'(cs_count - cs_before), 64'd0);
        check_eq("len0_words", {48'd0, words_done}, 64'd0);

        // COPY len=8 aborted during the third write, with a stray start mid-job.
        for (int i = 0; i < 8; i++) mem[16 + i] = 32'hC0DE_0000 + 32'(i);
        for (int i = 0; i < 3; i++) begin
            exp_rd_q.push_back(15'h0010 + 15'(i));
            exp_wr_q.push_back(wr_item(15'h0300 + 15'(i), 32'hC0DE_0000 + 32'(i)));
        end
        run_job(1'b0, 15'h0010, 15'h0300, 16'd8, 32'h0, 9, 5, cyc);
        check_eq("abort_cycles", 64'(cyc), 64'd11);
        check_eq("abort_words", {48'd0, words_done}, 64'd3);
        check_eq("abort_flag", {63'd0, aborted}, 64'd1);

        // Asynchronous reset in the middle of a COPY.
        mem[32] = 32'h0BAD_0001; mem[33] = 32'h0BAD_0002;
        exp_rd_q.push_back(15'h0020);
        exp_rd_q.push_back(15'h0021);
        exp_wr_q.push_back(wr_item(15'h0400, 32'h0BAD_0001));
        @(negedge clk);
        op = 1'b0; src = 15'h0020; dst = 15'h0400; len = 16'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_busy_done", {62'd0, busy, done}, 64'd0);
        check_eq("mid_rst_aborted", {63'd0, aborted}, 64'd0);
        check_eq("mid_rst_words", {48'd0, words_done}, 64'd0);
        check_eq("mid_rst_bus", {15'd0, m_cs, m_write, m_address, m_wdata}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("rst_rd_sb_empty", 64'(exp_rd_q.size()), 64'd0);
        check_eq("rst_wr_sb_empty", 64'(exp_wr_q.size()), 64'd0);

        exp_wr_q.push_back(wr_item(15'h0040, 32'h1234_5678));
        run_job(1'b1, 15'h0, 15'h0040, 16'd1, 32'h1234_5678, 0, 0, cyc);
        check_eq("post_rst_cycles", 64'(cyc), 64'd3);
        check_eq("post_rst_words", {48'd0, words_done}, 64'd1);
        check_eq("post_rst_aborted", {63'd0, aborted}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/avalon_mem_copy_master.md
# avalon_mem_copy_master

Avalon-MM master that drives the single-port on-chip RAM slave (32-bit data, 15-bit word address, byteenable, fixed read latency, no waitrequest). It runs word-granular COPY (read src, write dst) and FILL (write constant) jobs from a simple start/done command port. The game logic uses it to clear and initialise RAM regions without CPU involvement. It sits between the game control logic and the RAM's second slave port.

## Interface
- `ADDR_W`, 15: word address width.
- `DATA_W`, 32: data width; byteenable width is DATA_W/8.
- `LEN_W`, 16: job length width in words; must be ADDR_W+1 so a full 2^ADDR_W sweep is expressible.
- `READ_LATENCY`, 1: cycles from read issue to valid `m_readdata`; minimum 1.

Ports:
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: job request; sampled only when idle.
- `op` in 1: 0 = COPY, 1 = FILL.
- `src_addr` in ADDR_W: first source word (COPY only).
- `dst_addr` in ADDR_W: first destination word.
- `len` in LEN_W: word count.
- `fill_data` in DATA_W: FILL value.
- `abort` in 1: stop the current job.
- `busy` out 1: job in progress.
- `done` out 1: one-cycle completion pulse.
- `aborted` out 1: qualifies `done`; job was cut short.
- `words_done` out LEN_W: words written by the current or last job.
- `m_address` out ADDR_W, `m_chipselect` out 1, `m_write` out 1, `m_writedata` out DATA_W, `m_byteenable` out DATA_W/8, `m_clken` out 1: Avalon-MM master outputs.
- `m_readdata` in DATA_W: slave read data.

## Operation
- Reset values:
  - busy=0, done=0, aborted=0, words_done=0.
  - m_chipselect=0, m_write=0, m_address=0, m_writedata=0.
  - m_byteenable is all-ones and m_clken=1 at all times.
- States: IDLE, RD, RDWAIT, WR, FIN.
- IDLE:
  - On `start`, latch op, src, dst, len and fill_data, and clear words_done.
  - len=0 → go to FIN.
  - Otherwise go to RD for COPY, or WR for FILL.
- RD: chipselect=1, write=0, address=src. Go to RDWAIT.
- RDWAIT:
  - Stays READ_LATENCY cycles, with chipselect=0.
  - On its last cycle, captures `m_readdata` into a data register.
  - Then goes to WR.
- WR:
  - chipselect=1, write=1, address=dst.
  - writedata = captured word (COPY) or fill_data (FILL).
  - Then: src+1, dst+1, words_done+1.
  - If words_done+1 == len, go to FIN. Otherwise go to RD (COPY) or WR (FILL).
- FIN: drives no bus access. Next state is IDLE with done=1 for exactly one cycle.
- busy=1 in RD, RDWAIT, WR and FIN. busy=0 in IDLE.
- Address arithmetic is modulo 2^ADDR_W.
  - 0x7FFF+1 wraps to 0x0000.
  - There is no range check against physical depth (32000 words).
- Copy direction is always ascending. Overlap with dst>src replicates data; this is the defined behaviour.
- `abort`:
  - Sampled in RD, RDWAIT and WR.
  - A WR-cycle access in flight that cycle still completes.
  - Next state is FIN; done and aborted assert together.
  - words_done holds the number of writes issued.
- `start` while busy is ignored. Command inputs are don't-care outside the IDLE start cycle.
- `start` in the same cycle as the done pulse is accepted.
- aborted clears on the next accepted start.

## Timing
- COPY costs 2+READ_LATENCY cycles per word. With READ_LATENCY=1:
  - Read at T, capture at end of T+1, write at T+2, next read at T+3.
- FILL costs 1 cycle per word; writes are back-to-back.
- Start-to-first-access is 1 cycle: start sampled at edge E, first access in the cycle after E.
- Last WR cycle → FIN cycle → done in the following cycle.
- Job overhead is 2 cycles. len=0 gives done 2 cycles after start.
- All outputs are registered. m_readdata is the only input sampled combinationally into the capture register.

## Structure
- Shared package `pongers_mem_pkg`:
  - op encoding constants OP_COPY/OP_FILL.
  - State enum.
  - Default widths ADDR_W/DATA_W.
- Single module. The RDWAIT latency counter and address/count registers are inline, so no sub-module is warranted.

## Test plan
- FILL: dst=0x0100, len=4, fill=0xDEADBEEF → four consecutive write cycles to 0x0100..0x0103, then done with words_done=4 and aborted=0.
- COPY: src=0x0000 preloaded 0x11,0x22,0x33; dst=0x0200; len=3 → reads/writes every 3 cycles, RAM[0x200..0x202]=0x11,0x22,0x33, done after 11 cycles.
- Wrap: FILL dst=0x7FFE, len=3 → writes to 0x7FFE, 0x7FFF, 0x0000.
- len=0 → no chipselect ever asserted; done 2 cycles after start.
- Abort: COPY len=8, abort asserted in the WR of the 3rd word → 3rd write completes, done+aborted, words_done=3. Start pulsed mid-job has no effect.
- Reset: reset_n low mid-COPY → all outputs at reset values immediately; after release, a new FILL len=1 completes normally.
